// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers x/y/de, lock status and a fault count from a VGA hsync/vsync pair
module vga_sync_decoder #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int H_VIS   = 640,
  parameter int V_VIS   = 480
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FIRST = 10'(H_START);
  localparam logic [9:0] V_FIRST = 10'(V_START);
  localparam logic [9:0] H_END   = 10'(H_START + H_VIS - 1);
  localparam logic [9:0] V_END   = 10'(V_START + V_VIS - 1);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     state;
  logic [1:0] hs_sync;
  logic [1:0] vs_sync;
  logic       hs_hist;
  logic       vs_at_edge;
  logic       bad_flag;
  logic       fs_pend;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] err_cnt;

  logic hs_s;
  logic vs_s;
  logic hs_edge;
  logic vs_start;
  logic line_bad;
  logic frame_bad;
  logic h_lost;
  logic visible;
  logic fault;

  assign hs_s      = hs_sync[1];
  assign vs_s      = vs_sync[1];
  assign hs_edge   = hs_hist & ~hs_s;
  // vsync must have been high at the previous line start so a multi-line vsync counts once
  assign vs_start  = hs_edge & ~vs_s & vs_at_edge;
  assign line_bad  = hs_edge && (h_cnt != H_LAST);
  assign frame_bad = (v_cnt != V_LAST);
  assign h_lost    = (h_cnt == CNT_MAX);
  assign visible   = (h_cnt >= H_FIRST) && (h_cnt <= H_END) &&
                     (v_cnt >= V_FIRST) && (v_cnt <= V_END);
  assign fault     = line_bad || (vs_start && frame_bad) || h_lost;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      hs_sync <= 2'b11;
      vs_sync <= 2'b11;
      hs_hist <= 1'b1;
    end else begin
      hs_sync <= {hs_sync[0], hsync};
      vs_sync <= {vs_sync[0], vsync};
      hs_hist <= hs_s;
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      h_cnt      <= '0;
      v_cnt      <= '0;
      vs_at_edge <= 1'b1;
      bad_flag   <= 1'b0;
      fs_pend    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      fs_pend <= 1'b0;

      if (hs_edge)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 10'd1;

      if (hs_edge) begin
        vs_at_edge <= vs_s;
        if (vs_start)
          v_cnt <= '0;
        else if (v_cnt != CNT_MAX)
          v_cnt <= v_cnt + 10'd1;
      end

      case (state)
        SEARCH: begin
          if (vs_start) begin
            state    <= VERIFY;
            bad_flag <= 1'b0;
          end
        end
        VERIFY: begin
          if (vs_start) begin
            bad_flag <= 1'b0;
            if (!bad_flag && !line_bad && !frame_bad) begin
              state   <= LOCKED;
              fs_pend <= 1'b1;
            end
          end else if (line_bad) begin
            bad_flag <= 1'b1;
          end
        end
        LOCKED: begin
          // one fault event bumps the counter once even when several checks trip together
          if (fault) begin
            state <= SEARCH;
            if (err_cnt != 8'hff)
              err_cnt <= err_cnt + 8'd1;
          end else if (vs_start) begin
            fs_pend <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err_count   <= '0;
    end else begin
      de          <= (state == LOCKED) && visible;
      x           <= ((state == LOCKED) && visible) ? (h_cnt - H_FIRST) : 10'd0;
      y           <= ((state == LOCKED) && visible) ? (v_cnt - V_FIRST) : 10'd0;
      locked      <= (state == LOCKED);
      frame_start <= fs_pend;
      err_count   <= err_cnt;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a scaled-down 40x12 raster
module tb_vga_sync_decoder;

  localparam int HT = 40;
  localparam int VT = 12;
  localparam int HS = 8;
  localparam int VS = 3;
  localparam int HV = 24;
  localparam int VV = 6;
  localparam int HS_W = 4;
  localparam int VS_W = 1;

  logic       clk;
  logic       rst;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic       locked;
  logic       frame_start;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int vs_cyc = 0;
  int de_total = 0;
  int fs_total = 0;
  int fs_cyc = 0;
  int lock_cyc = 0;
  int unlock_cyc = 0;
  int fx = -1, fy = -1, lx = -1, ly = -1;
  int bad_xy = 0;
  int bad_run = 0;
  int run = 0;
  bit want_first = 0;
  bit prev_de = 0;
  bit prev_locked = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .H_VIS(HV), .V_VIS(VV)
  ) dut (
    .clk_25mhz  (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .x          (x),
    .y          (y),
    .de         (de),
    .locked     (locked),
    .frame_start(frame_start),
    .err_count  (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      prev_de = 0;
      prev_locked = 0;
    end else begin
      if (de) de_total++;
      if (!de && (x != 10'd0 || y != 10'd0)) bad_xy++;
      if (de && !locked) bad_xy++;
      if (frame_start) begin
        fs_total++;
        fs_cyc = cyc;
        want_first = 1;
      end
      if (de) begin
        if (want_first) begin
          fx = int'(x);
          fy = int'(y);
          want_first = 0;
        end
        lx = int'(x);
        ly = int'(y);
        run++;
      end else begin
        if (prev_de && run != HV) bad_run++;
        run = 0;
      end
      if (locked && !prev_locked) lock_cyc = cyc;
      if (!locked && prev_locked) unlock_cyc = cyc;
      prev_de = de;
      prev_locked = locked;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_cycle(input int h, input int line);
    @(posedge clk);
    #1;
    hsync = (h < HS_W) ? 1'b0 : 1'b1;
    vsync = (line < VS_W) ? 1'b0 : 1'b1;
    if (h == 0 && line == 0) vs_cyc = cyc;
  endtask

  task automatic drive_line(input int len, input int line);
    for (int h = 0; h < len; h++) drive_cycle(h, line);
  endtask

  task automatic drive_frame(input int lines, input int long_line);
    for (int l = 0; l < lines; l++) drive_line((l == long_line) ? HT + 1 : HT, l);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hsync = 1'b1;
      vsync = 1'b1;
    end
  endtask

  int de_snap;
  int fs_snap;

  initial begin
    rst = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      hsync = ~hsync;
      vsync = (i % 3 == 0) ? 1'b0 : 1'b1;
    end
    #5;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_de", int'(de), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_err", int'(err_count), 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle(3);

    drive_frame(VT, -1);
    check("f1_not_locked", int'(locked), 0);
    check("f1_no_fs", fs_total, 0);

    drive_frame(VT, -1);
    check("f2_locked", int'(locked), 1);
    check("lock_latency", lock_cyc - vs_cyc, 4);
    check("fs_latency", fs_cyc - vs_cyc, 4);
    check("first_x", fx, 0);
    check("first_y", fy, 0);
    check("last_x", lx, HV - 1);
    check("last_y", ly, VV - 1);

    de_snap = de_total;
    drive_frame(VT, -1);
    check("f3_de_cycles", de_total - de_snap, HV * VV);
    check("f3_fs_count", fs_total, 2);

    drive_frame(VT, 5);
    check("long_unlocked", int'(locked), 0);
    check("long_err", int'(err_count), 1);
    drive_frame(VT, -1);
    check("long_still_unlocked", int'(locked), 0);
    drive_frame(VT, -1);
    check("long_relocked", int'(locked), 1);
    check("long_err_hold", int'(err_count), 1);

    drive_frame(VT - 1, -1);
    fs_snap = fs_total;
    drive_frame(VT, -1);
    check("short_unlocked", int'(locked), 0);
    check("short_err", int'(err_count), 2);
    check("short_no_fs", fs_total, fs_snap);
    check("short_unlock_latency", unlock_cyc - vs_cyc, 4);
    drive_frame(VT, -1);
    drive_frame(VT, -1);
    check("short_relocked", int'(locked), 1);

    drive_frame(VT, VT - 1);
    drive_frame(VT, -1);
    check("simul_err_once", int'(err_count), 3);
    check("simul_unlocked", int'(locked), 0);
    drive_frame(VT, -1);
    drive_frame(VT, -1);
    check("simul_relocked", int'(locked), 1);

    for (int l = 0; l < 10; l++) drive_line(HT, l);
    drive_idle(1100);
    check("loss_unlocked", int'(locked), 0);
    check("loss_err", int'(err_count), 4);
    de_snap = de_total;
    drive_frame(VT, -1);
    check("loss_no_de", de_total - de_snap, 0);
    check("loss_still_unlocked", int'(locked), 0);
    drive_frame(VT, -1);
    check("loss_relocked", int'(locked), 1);

    for (int l = 0; l < 4; l++) drive_line(HT, l);
    for (int h = 0; h < 20; h++) drive_cycle(h, 4);
    check("pre_rst_de", int'(de), 1);
    #5;
    rst = 1'b1;
    #2;
    check("arst_de", int'(de), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_x", int'(x), 0);
    check("arst_y", int'(y), 0);
    check("arst_err", int'(err_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fx = -1;
    fy = -1;
    drive_frame(VT, -1);
    check("arst_f1_unlocked", int'(locked), 0);
    drive_frame(VT, -1);
    check("arst_relocked", int'(locked), 1);
    check("arst_first_x", fx, 0);
    check("arst_first_y", fy, 0);
    check("arst_err_after", int'(err_count), 0);

    check("idle_xy_and_de_lock", bad_xy, 0);
    check("de_run_length", bad_run, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
